// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and the loader port.
// Define MEM_ARB_PERF_EN to add the grant/wait performance counters.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_done,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
`ifdef MEM_ARB_PERF_EN
  ,output logic [31:0]       perf_cpu_gnt,
   output logic [31:0]       perf_ldr_gnt,
   output logic [31:0]       perf_wait
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       last_owner;
   logic       any_req;
   logic       win;

   assign any_req = cpu_req | ldr_req;

   // On a tie the requester that did not win last time is served.
   always_comb begin
      win = ldr_req;
      if (cpu_req && ldr_req) win = ~last_owner;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_owner <= 1'b1;
         owner      <= 1'b0;
         busy       <= 1'b0;
         cpu_done   <= 1'b0;
         ldr_done   <= 1'b0;
         rdata      <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         cpu_done <= 1'b0;
         ldr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state      <= BUSY;
                  owner      <= win;
                  last_owner <= win;
                  busy       <= 1'b1;
                  mem_en     <= 1'b1;
                  mem_we     <= win ? ldr_we    : cpu_we;
                  mem_addr   <= win ? ldr_addr  : cpu_addr;
                  mem_wdata  <= win ? ldr_wdata : cpu_wdata;
                  cnt        <= 4'(MEM_LAT - 1);
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state     <= DONE;
                  if (!mem_we) rdata <= mem_rdata;
                  mem_en    <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  cpu_done  <= ~owner;
                  ldr_done  <= owner;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_PERF_EN
   // Wait cycles: the tie loser at a grant edge, plus the non-owner requesting during BUSY.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_cpu_gnt <= '0;
         perf_ldr_gnt <= '0;
         perf_wait    <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            if (win) perf_ldr_gnt <= perf_ldr_gnt + 32'd1;
            else     perf_cpu_gnt <= perf_cpu_gnt + 32'd1;
         end
         if ((state == IDLE && cpu_req && ldr_req) ||
             (state == BUSY && (owner ? cpu_req : ldr_req)))
            perf_wait <= perf_wait + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two lanes (MEM_LAT=2 and MEM_LAT=1), each with a
// time-offset reference model compared every cycle, directed scenarios and random traffic.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL lane%0d %s: got 0x%08h want 0x%08h", ln, nm, act, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return (a * 32'h9E3779B9) ^ 32'h5A5A5A5A;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : lane
      localparam int LAT = (gi == 0) ? 2 : 1;

      logic        rst, cpu_req, cpu_we, ldr_req, ldr_we;
      logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
      logic        cpu_done, ldr_done, mem_en, mem_we, busy, owner;
      logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
      logic [31:0] perf_cpu_gnt, perf_ldr_gnt, perf_wait;
`endif
      bit fin = 1'b0;

      assign mem_rdata = memf(mem_addr);

      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
         .clk(clk), .rst(rst),
         .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
         .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_done(ldr_done),
         .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
         .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
`ifdef MEM_ARB_PERF_EN
        ,.perf_cpu_gnt(perf_cpu_gnt), .perf_ldr_gnt(perf_ldr_gnt), .perf_wait(perf_wait)
`endif
      );

      // Reference model: an access granted at edge gt is in memory phase for offsets 0..LAT-1,
      // completes at offset LAT, and the arbiter is free again from offset LAT+1.
      int          edge_n = 0;
      bit          started = 1'b0;
      bit          act = 1'b0;
      int          gt = 0;
      int          d, dd;
      bit          m_own = 1'b0, m_last = 1'b1, a_we = 1'b0;
      logic [31:0] a_addr = '0, a_wdata = '0, m_rdata = '0;
      int          m_cg = 0, m_lg = 0, m_w = 0;

      always @(posedge clk) begin
         edge_n++;
         if (!rst) begin
            started = 1'b1; act = 1'b0; m_last = 1'b1; m_own = 1'b0; m_rdata = '0;
            m_cg = 0; m_lg = 0; m_w = 0;
         end else if (act) begin
            d = edge_n - gt;
            if (d <= LAT && (m_own ? cpu_req : ldr_req)) m_w++;
            if (d == LAT && !a_we) m_rdata = memf(a_addr);
            if (d == LAT + 1) act = 1'b0;
         end else if (cpu_req || ldr_req) begin
            if (cpu_req && ldr_req) begin
               m_own = !m_last;
               m_w++;
            end else begin
               m_own = ldr_req;
            end
            m_last  = m_own;
            act     = 1'b1;
            gt      = edge_n;
            a_we    = m_own ? ldr_we    : cpu_we;
            a_addr  = m_own ? ldr_addr  : cpu_addr;
            a_wdata = m_own ? ldr_wdata : cpu_wdata;
            if (m_own) m_lg++; else m_cg++;
         end
      end

      always @(negedge clk) begin
         if (started) begin
            dd = edge_n - gt;
            check("mem_en",    gi, 32'(mem_en),    32'(act && dd < LAT));
            check("mem_we",    gi, 32'(mem_we),    32'(act && dd < LAT && a_we));
            check("mem_addr",  gi, mem_addr,       (act && dd < LAT) ? a_addr  : 32'h0);
            check("mem_wdata", gi, mem_wdata,      (act && dd < LAT) ? a_wdata : 32'h0);
            check("busy",      gi, 32'(busy),      32'(act));
            check("owner",     gi, 32'(owner),     32'(m_own));
            check("rdata",     gi, rdata,          m_rdata);
            check("cpu_done",  gi, 32'(cpu_done),  32'(act && dd == LAT && !m_own));
            check("ldr_done",  gi, 32'(ldr_done),  32'(act && dd == LAT && m_own));
`ifdef MEM_ARB_PERF_EN
            check("perf_cpu_gnt", gi, perf_cpu_gnt, 32'(m_cg));
            check("perf_ldr_gnt", gi, perf_ldr_gnt, 32'(m_lg));
            check("perf_wait",    gi, perf_wait,    32'(m_w));
`endif
         end
      end

      bit cpu_rel = 1'b0, ldr_rel = 1'b0;
      always @(negedge clk) begin
         if (cpu_done) cpu_rel = 1'b1;
         if (ldr_done) ldr_rel = 1'b1;
      end

      // Starts and ends at posedge+2; lat counts negedges from the request to the done pulse.
      task automatic run_one(input bit who, input bit we, input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output int en, output int oth, output int bad);
         if (who) begin ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = wd; end
         else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
         lat = 99; en = 0; oth = 0; bad = 0;
         for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (mem_en) begin
               en++;
               if (mem_addr !== a || mem_wdata !== wd || mem_we !== we) bad++;
            end
            if (who ? cpu_done : ldr_done) oth++;
            if (who ? ldr_done : cpu_done) begin lat = n; break; end
         end
         @(posedge clk); #2;
         if (who) ldr_req = 1'b0; else cpu_req = 1'b0;
      endtask

      initial begin
         int lat, en, oth, bad, nd, n;
         int ord[3];
         bit cpu_pend, ldr_pend;
         rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
         ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
         repeat (3) @(posedge clk);
         #2 rst = 1'b1;

         // CPU read of 0x10
         run_one(1'b0, 1'b0, 32'h10, 32'h0, lat, en, oth, bad);
         check("t1_latency", gi, lat, LAT + 2);
         check("t1_en_cycles", gi, en, LAT);
         check("t1_ldr_done", gi, oth, 0);
         check("t1_rdata", gi, rdata, 32'hDEADBEEF);

         // Loader write leaves rdata alone
         run_one(1'b1, 1'b1, 32'h40, 32'h12345678, lat, en, oth, bad);
         check("t3_latency", gi, lat, LAT + 2);
         check("t3_we_cycles", gi, en, LAT);
         check("t3_stable", gi, bad, 0);
         check("t3_cpu_done", gi, oth, 0);
         check("t3_rdata", gi, rdata, 32'hDEADBEEF);

         // Simultaneous held requests after reset
         rst = 1'b0; @(posedge clk); #2 rst = 1'b1;
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
         ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h200;
         nd = 0; ord = '{9, 9, 9};
         for (int i = 0; i < 60 && nd < 3; i++) begin
            @(negedge clk);
            if (cpu_done || ldr_done) begin ord[nd] = int'(owner); nd++; end
         end
         check("t2_dones", gi, nd, 3);
         check("t2_owner0", gi, ord[0], 0);
         check("t2_owner1", gi, ord[1], 1);
         check("t2_owner2", gi, ord[2], 0);
`ifdef MEM_ARB_PERF_EN
         check("t6_cpu_gnt", gi, perf_cpu_gnt, 2);
         check("t6_ldr_gnt", gi, perf_ldr_gnt, 1);
         check("t6_wait", gi, perf_wait, 3 * (LAT + 1));
`endif
         @(posedge clk); #2 cpu_req = 1'b0; ldr_req = 1'b0;

         // Reset in the middle of an access
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_wdata = '0;
         @(posedge clk); #2;
         if (LAT >= 2) begin @(posedge clk); #2; end
         rst = 1'b0; cpu_req = 1'b0;
         @(posedge clk); #2 rst = 1'b1;
         @(negedge clk);
         check("t4_busy", gi, 32'(busy), 0);
         check("t4_mem_en", gi, 32'(mem_en), 0);
         check("t4_cpu_done", gi, 32'(cpu_done), 0);
         check("t4_rdata", gi, rdata, 0);
         @(posedge clk); #2;
         run_one(1'b0, 1'b0, 32'h30, 32'h0, lat, en, oth, bad);
         check("t4_after_latency", gi, lat, LAT + 2);
         check("t4_after_rdata", gi, rdata, memf(32'h30));

         // Back-to-back CPU reads, request held
         cpu_req = 1'b1; cpu_we = 1'b0;
         for (int k = 0; k < 4; k++) begin
            cpu_addr = 32'h80 + 32'(k * 4);
            n = 99;
            for (int j = 1; j <= 20; j++) begin
               @(negedge clk);
               if (cpu_done) begin n = j; break; end
            end
            check("t5_spacing", gi, n, LAT + 2);
            check("t5_rdata", gi, rdata, memf(32'h80 + 32'(k * 4)));
            @(posedge clk); #2;
         end
         cpu_req = 1'b0;
         @(posedge clk); #2;

         // Random traffic with occasional resets
         cpu_pend = 1'b0; ldr_pend = 1'b0; cpu_rel = 1'b0; ldr_rel = 1'b0;
         for (int c = 0; c < 400; c++) begin
            @(posedge clk); #2;
            rst = ($urandom_range(0, 59) != 0);
            if (cpu_pend && cpu_rel) begin cpu_pend = 1'b0; cpu_req = 1'b0; end
            if (ldr_pend && ldr_rel) begin ldr_pend = 1'b0; ldr_req = 1'b0; end
            if (!cpu_pend && $urandom_range(0, 2) == 0) begin
               cpu_pend = 1'b1; cpu_rel = 1'b0; cpu_req = 1'b1;
               cpu_we = 1'($urandom_range(0, 1));
               cpu_addr = $urandom_range(0, 31) << 2;
               cpu_wdata = $urandom;
            end
            if (!ldr_pend && $urandom_range(0, 2) == 0) begin
               ldr_pend = 1'b1; ldr_rel = 1'b0; ldr_req = 1'b1;
               ldr_we = 1'($urandom_range(0, 1));
               ldr_addr = $urandom_range(0, 31) << 2;
               ldr_wdata = $urandom;
            end
         end
         rst = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;
         repeat (8) @(posedge clk);
         fin = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 20000 && !(lane[0].fin && lane[1].fin); i++) @(posedge clk);
      if (!(lane[0].fin && lane[1].fin)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: lanes finished=%0d/%0d required=1/1", lane[0].fin, lane[1].fin);
      end
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
